abc_buffer: RTL and testbench

ABC_BUFFER -- requirements
Module: abc_buffer

---
 rtl/abc_buffer.sv | 101 ++++++++++
 tb/tb_abc_buffer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/abc_buffer.sv
//------------------------------------------------------------------------------
// abc_buffer : DEPTH-entry FIFO for 3-bit ABC result words. Optional macro
//              ABC_BUFFER_PARITY_EN adds a stored even-parity bit and out_par.
// Revision   : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module abc_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                       Clock,
    input  logic                       Reset_b,
    input  logic [2:0]                 ABC,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [2:0]                 out_ABC,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count
`ifdef ABC_BUFFER_PARITY_EN
    ,
    output logic                       out_par
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
`ifdef ABC_BUFFER_PARITY_EN
    localparam int ENTRY_W = 4;
`else
    localparam int ENTRY_W = 3;
`endif
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
    localparam logic [PTR_W-1:0] ONE_PTR  = PTR_W'(1);

    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [ENTRY_W-1:0] r_last;

    logic               w_wr;
    logic               w_rd;
    logic [ENTRY_W-1:0] w_entry;
    logic [ENTRY_W-1:0] w_head;
    logic [ENTRY_W-1:0] w_out;

    assign in_ready  = (r_count != FULL_CNT);
    assign out_valid = (r_count != '0);
    assign count     = r_count;

    assign w_wr = in_valid & in_ready;
    assign w_rd = out_valid & out_ready;

`ifdef ABC_BUFFER_PARITY_EN
    assign w_entry = {^ABC, ABC};
`else
    assign w_entry = ABC;
`endif

    // When empty, keep showing the last word handed out (zero after reset)
    // rather than whatever stale entry the read pointer now lands on.
    assign w_head  = r_mem[r_rd_ptr];
    assign w_out   = out_valid ? w_head : r_last;
    assign out_ABC = w_out[2:0];
`ifdef ABC_BUFFER_PARITY_EN
    assign out_par = w_out[3];
`endif

    always_ff @(posedge Clock) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    always_ff @(posedge Clock or negedge Reset_b) begin
        if (!Reset_b) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_last   <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + ONE_PTR;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + ONE_PTR;
                r_last   <= w_head;
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + ONE_CNT;
                2'b01:   r_count <= r_count - ONE_CNT;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_abc_buffer.sv
//------------------------------------------------------------------------------
// tb_abc_buffer : directed and randomized checks of abc_buffer against a
//                 queue-based FIFO model.
// Revision      : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_abc_buffer;

    localparam int DEPTH = 4;

    logic       Clock = 1'b0;
    logic       Reset_b;
    logic [2:0] ABC;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] out_ABC;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] count;
`ifdef ABC_BUFFER_PARITY_EN
    logic       out_par;
`endif

    int total = 0;
    int bad   = 0;

    logic [2:0] q[$];
    logic [2:0] last_abc;

    always #5 Clock = ~Clock;

    abc_buffer #(.DEPTH(DEPTH)) dut (
        .Clock    (Clock),
        .Reset_b  (Reset_b),
        .ABC      (ABC),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_ABC  (out_ABC),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .count    (count)
`ifdef ABC_BUFFER_PARITY_EN
        ,
        .out_par  (out_par)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Compare every output against the model's view of the buffer.
    task automatic check_state();
        check("count", 32'(count), 32'(q.size()));
        check("out_valid", 32'(out_valid), 32'(q.size() != 0));
        check("in_ready", 32'(in_ready), 32'(q.size() != DEPTH));
        if (q.size() != 0) begin
            check("out_ABC", 32'(out_ABC), 32'(q[0]));
`ifdef ABC_BUFFER_PARITY_EN
            check("out_par", 32'(out_par), 32'(^q[0]));
`endif
        end else begin
            check("out_ABC_hold", 32'(out_ABC), 32'(last_abc));
`ifdef ABC_BUFFER_PARITY_EN
            check("out_par_hold", 32'(out_par), 32'(^last_abc));
`endif
        end
    endtask

    // Called at a falling edge: check, drive, advance one rising edge.
    task automatic cycle(input logic v, input logic [2:0] a, input logic r);
        bit do_wr;
        bit do_rd;
        check_state();
        in_valid  = v;
        ABC       = a;
        out_ready = r;
        do_wr = v && (q.size() < DEPTH);
        do_rd = r && (q.size() > 0);
        @(posedge Clock);
        if (do_rd) last_abc = q.pop_front();
        if (do_wr) q.push_back(a);
        @(negedge Clock);
    endtask

    // Pulse reset low between clock edges and check it takes effect at once.
    task automatic async_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #2 Reset_b = 1'b0;
        #1;
        check("rst_count", 32'(count), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_ABC", 32'(out_ABC), 32'd0);
`ifdef ABC_BUFFER_PARITY_EN
        check("rst_out_par", 32'(out_par), 32'd0);
`endif
        q.delete();
        last_abc = 3'b000;
        #1 Reset_b = 1'b1;
        @(negedge Clock);
    endtask

    initial begin
        Reset_b   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        ABC       = 3'b000;
        last_abc  = 3'b000;
        repeat (2) @(negedge Clock);
        check("reset_count", 32'(count), 32'd0);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_ABC", 32'(out_ABC), 32'd0);
        Reset_b = 1'b1;
        @(negedge Clock);

        // Single write appears the next cycle.
        cycle(1'b1, 3'b101, 1'b0);
        check("lat_out_ABC", 32'(out_ABC), 32'h5);
        check("lat_count", 32'(count), 32'd1);
        cycle(1'b0, 3'b000, 1'b1);

        // Fill, overflow attempt, drain.
        cycle(1'b1, 3'b001, 1'b0);
        cycle(1'b1, 3'b010, 1'b0);
        cycle(1'b1, 3'b011, 1'b0);
        cycle(1'b1, 3'b100, 1'b0);
        check("full_in_ready", 32'(in_ready), 32'd0);
        cycle(1'b1, 3'b111, 1'b0);
        check("full_count", 32'(count), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check("drain_out_ABC", 32'(out_ABC), 32'(i + 1));
            cycle(1'b0, 3'b000, 1'b1);
        end
        check("drained_valid", 32'(out_valid), 32'd0);

        // Full with simultaneous write and read: only the read happens.
        for (int i = 0; i < 4; i++) cycle(1'b1, 3'(i), 1'b0);
        cycle(1'b1, 3'b110, 1'b1);
        check("full_rw_count", 32'(count), 32'd3);
        for (int i = 0; i < 3; i++) cycle(1'b0, 3'b000, 1'b1);

        // Steady count=2 with concurrent write/read across pointer wrap.
        cycle(1'b1, 3'b111, 1'b0);
        cycle(1'b1, 3'b110, 1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b1, 3'(i), 1'b1);
        check("steady_count", 32'(count), 32'd2);
        check("steady_head", 32'(out_ABC), 32'h4);
        cycle(1'b1, 3'b000, 1'b0);

        // Asynchronous reset with three stored words.
        check("pre_rst_count", 32'(count), 32'd3);
        async_reset();
        cycle(1'b1, 3'b011, 1'b0);
        check("post_rst_head", 32'(out_ABC), 32'h3);

`ifdef ABC_BUFFER_PARITY_EN
        cycle(1'b0, 3'b000, 1'b1);
        cycle(1'b1, 3'b111, 1'b0);
        check("par_111", 32'(out_par), 32'd1);
        cycle(1'b1, 3'b110, 1'b1);
        check("par_110", 32'(out_par), 32'd0);
`endif

        // Randomized traffic in phases with varying write/read pressure.
        for (int i = 0; i < 400; i++) begin
            int pv;
            int pr;
            case (i / 100)
                0:       begin pv = 80; pr = 30; end
                1:       begin pv = 30; pr = 80; end
                2:       begin pv = 50; pr = 50; end
                default: begin pv = 90; pr = 90; end
            endcase
            if (i == 250) async_reset();
            cycle(($urandom_range(0, 99) < pv), 3'($urandom), ($urandom_range(0, 99) < pr));
        end
        check_state();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
